// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a valid/ready load port.
// A word is reloaded on the edge that ends the previous word's last bit, so consecutive words stream with no idle gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             o,
  output logic             o_valid,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_ordered;
  logic             w_accept;

  // The shift register always sends from its MSB, so LSB-first words are bit-reversed on load.
  always_comb begin
    w_ordered = din;
    if (MSB_FIRST == 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        w_ordered[i] = din[WIDTH-1-i];
      end
    end
  end

  assign load_ready = (r_state == IDLE) || ((r_state == SHIFT) && (r_count == '0));
  assign w_accept   = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_shift <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      last    <= 1'b0;
    end else if (w_accept) begin
      // The first bit goes straight to o, and the remaining bits are kept in r_shift.
      r_state <= SHIFT;
      r_count <= CW'(WIDTH - 1);
      r_shift <= w_ordered << 1;
      o       <= w_ordered[WIDTH-1];
      o_valid <= 1'b1;
      last    <= (WIDTH == 1);
    end else if (r_state == SHIFT && r_count != '0) begin
      r_count <= r_count - 1'b1;
      r_shift <= r_shift << 1;
      o       <= r_shift[WIDTH-1];
      o_valid <= 1'b1;
      last    <= (r_count == CW'(1));
    end else begin
      r_state <= IDLE;
      r_count <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      last    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: 8-bit MSB-first, 8-bit LSB-first and 1-bit instances.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din_m, din_l;
  logic [0:0] din_1;
  logic       valid_m, valid_l, valid_1;
  logic       ready_m, ready_l, ready_1;
  logic       o_m, o_l, o_1;
  logic       ov_m, ov_l, ov_1;
  logic       last_m, last_l, last_1;

  int checks = 0;
  int errors = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din_m), .load_valid(valid_m), .load_ready(ready_m),
    .o(o_m), .o_valid(ov_m), .last(last_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_l), .load_valid(valid_l), .load_ready(ready_l),
    .o(o_l), .o_valid(ov_l), .last(last_l)
  );

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1)) u_w1 (
    .clk(clk), .rst(rst), .din(din_1), .load_valid(valid_1), .load_ready(ready_1),
    .o(o_1), .o_valid(ov_1), .last(last_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 1'b0;
    #2;
    checks++;
    if ({o_m, ov_m, last_m} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000", {o_m, ov_m, last_m});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready_m, ready_l, ready_1} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 111", {ready_m, ready_l, ready_1});
    end
  endtask

  task automatic test_single;
    logic [7:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h01;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      din_m   = words[w];
      valid_m = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 0) valid_m = 1'b0;
        checks++;
        if ({o_m, ov_m, last_m} !== {words[w][7-k], 1'b1, (k == 7)}) begin
          errors++;
          $display("FAIL single_bit w=%0d k=%0d: got o/ov/last=%b expected %b",
                   w, k, {o_m, ov_m, last_m}, {words[w][7-k], 1'b1, (k == 7)});
        end
      end
      @(negedge clk);
      checks++;
      if ({o_m, ov_m, last_m} !== 3'b000) begin
        errors++;
        $display("FAIL single_end w=%0d: got o/ov/last=%b expected 000", w, {o_m, ov_m, last_m});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] seq;
    seq = {8'hA5, 8'h3C};
    @(negedge clk);
    din_m   = 8'hA5;
    valid_m = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) din_m = 8'h3C;
      if (k == 8) valid_m = 1'b0;
      checks++;
      if ({o_m, ov_m, last_m} !== {seq[15-k], 1'b1, (k == 7 || k == 15)}) begin
        errors++;
        $display("FAIL b2b_bit k=%0d: got o/ov/last=%b expected %b",
                 k, {o_m, ov_m, last_m}, {seq[15-k], 1'b1, (k == 7 || k == 15)});
      end
    end
    @(negedge clk);
    checks++;
    if (ov_m !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got o_valid=%b expected 0", ov_m);
    end
  endtask

  task automatic test_busy;
    logic [15:0] seq;
    seq = {8'hA5, 8'hFF};
    @(negedge clk);
    din_m   = 8'hA5;
    valid_m = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) din_m = 8'hFF;
      if (k == 8) valid_m = 1'b0;
      checks++;
      if (o_m !== seq[15-k] || ov_m !== 1'b1) begin
        errors++;
        $display("FAIL busy_bit k=%0d: got o=%b ov=%b expected o=%b ov=1", k, o_m, ov_m, seq[15-k]);
      end
      if (k < 8) begin
        checks++;
        if (ready_m !== (k == 7)) begin
          errors++;
          $display("FAIL busy_ready k=%0d: got %b expected %b", k, ready_m, (k == 7));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lsb_first;
    logic [7:0] exp_bits;
    exp_bits = 8'b1000_0000;
    @(negedge clk);
    din_l   = 8'h01;
    valid_l = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) valid_l = 1'b0;
      checks++;
      if ({o_l, ov_l, last_l} !== {exp_bits[7-k], 1'b1, (k == 7)}) begin
        errors++;
        $display("FAIL lsb_bit k=%0d: got o/ov/last=%b expected %b",
                 k, {o_l, ov_l, last_l}, {exp_bits[7-k], 1'b1, (k == 7)});
      end
    end
    @(negedge clk);
    checks++;
    if (ov_l !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end: got o_valid=%b expected 0", ov_l);
    end
  endtask

  task automatic test_abort;
    logic [7:0] w;
    w = 8'h3C;
    @(negedge clk);
    din_m   = 8'hA5;
    valid_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_m = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ov_m !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got o_valid=%b expected 1", ov_m);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({o_m, ov_m, last_m} !== 3'b000) begin
      errors++;
      $display("FAIL abort_async: got o/ov/last=%b expected 000", {o_m, ov_m, last_m});
    end
    #1 rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (ov_m !== 1'b0 || ready_m !== 1'b1) begin
        errors++;
        $display("FAIL abort_quiet k=%0d: got ov=%b ready=%b expected ov=0 ready=1", k, ov_m, ready_m);
      end
    end
    din_m   = w;
    valid_m = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) valid_m = 1'b0;
      checks++;
      if ({o_m, ov_m, last_m} !== {w[7-k], 1'b1, (k == 7)}) begin
        errors++;
        $display("FAIL abort_resend k=%0d: got o/ov/last=%b expected %b",
                 k, {o_m, ov_m, last_m}, {w[7-k], 1'b1, (k == 7)});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_width1;
    @(negedge clk);
    din_1   = 1'b1;
    valid_1 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_1, ov_1, last_1, ready_1} !== {(j % 2 == 0), 3'b111}) begin
        errors++;
        $display("FAIL w1_bit j=%0d: got o/ov/last/ready=%b expected %b",
                 j, {o_1, ov_1, last_1, ready_1}, {(j % 2 == 0), 3'b111});
      end
      din_1 = (j % 2 == 0) ? 1'b0 : 1'b1;
    end
    valid_1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov_1, last_1} !== 2'b00) begin
      errors++;
      $display("FAIL w1_end: got ov/last=%b expected 00", {ov_1, last_1});
    end
  endtask

  initial begin
    din_m = '0; din_l = '0; din_1 = '0;
    valid_m = 1'b0; valid_l = 1'b0; valid_1 = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy();
    test_lsb_first();
    test_abort();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
